// File: rtl/axi_rd_dma_ctrl_if.sv
// AXI4 read-address/read-data and AXI4-Stream bundles for the read DMA.
interface aximm_rd_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

interface axis_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tready;

    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axi_rd_dma_ctrl.sv
// Read DMA controller: splits a command into 4 KB-safe AR bursts and
// streams the returned R beats out on AXIS with a single command-level tlast.
module axi_rd_dma_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 256,
    parameter int MAX_BURST  = 16,
    parameter int MAX_OUTST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_beats,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    aximm_rd_if.master            m_axi,
    axis_if.master                m_axis
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int SZ  = $clog2(BPB);
    localparam int OW  = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           ar_rem;
    logic [15:0]           r_rem;
    logic [OW-1:0]         outst;
    logic                  acc;

    logic [16:0]           page_beats;
    logic [16:0]           burst;
    logic [15:0]           hs_beats;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  r_last_hs;
    logic                  r_bad;

    assign m_axis.tvalid  = m_axi.rvalid;
    assign m_axis.tdata   = m_axi.rdata;
    assign m_axi.rready   = m_axis.tready;
    assign m_axis.tlast   = (r_rem == 16'd1);
    assign m_axi.arsize   = 3'(SZ);
    assign m_axi.arburst  = 2'b01;
    assign cmd_ready      = (state == IDLE) && !rst;

    assign ar_hs     = m_axi.arvalid && m_axi.arready;
    assign r_hs      = m_axi.rvalid && m_axis.tready && (state != IDLE);
    assign r_last_hs = r_hs && m_axi.rlast;
    assign r_bad     = (m_axi.rresp != 2'b00);
    assign hs_beats  = 16'(m_axi.arlen) + 16'd1;

    // Largest burst that fits the remaining count, MAX_BURST and the 4 KB page
    always_comb begin
        page_beats = 17'((13'h1000 - {1'b0, addr[11:0]}) >> SZ);
        burst      = {1'b0, ar_rem};
        if (burst > 17'(MAX_BURST))
            burst = 17'(MAX_BURST);
        if (burst > page_beats)
            burst = page_beats;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            ar_rem        <= '0;
            r_rem         <= '0;
            outst         <= '0;
            acc           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            m_axi.arvalid <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arlen   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (r_hs) begin
                r_rem <= r_rem - 16'd1;
                if (r_bad)
                    acc <= 1'b1;
            end

            // Simultaneous AR issue and burst completion cancel out
            if (ar_hs && !r_last_hs)
                outst <= outst + OW'(1);
            else if (!ar_hs && r_last_hs)
                outst <= outst - OW'(1);

            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (cmd_valid) begin
                        addr   <= cmd_addr & ~ADDR_WIDTH'(BPB - 1);
                        ar_rem <= cmd_beats;
                        r_rem  <= cmd_beats;
                        acc    <= 1'b0;
                        if (cmd_beats == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (ar_hs) begin
                        m_axi.arvalid <= 1'b0;
                        addr          <= addr + (ADDR_WIDTH'(hs_beats) << SZ);
                        ar_rem        <= ar_rem - hs_beats;
                        if (ar_rem == hs_beats)
                            state <= DRAIN;
                    end else if (!m_axi.arvalid &&
                                 32'(outst) < MAX_OUTST) begin
                        m_axi.arvalid <= 1'b1;
                        m_axi.araddr  <= addr;
                        m_axi.arlen   <= 8'(burst - 17'd1);
                    end
                end
                DRAIN: begin
                    if (r_hs && r_rem == 16'd1) begin
                        done  <= 1'b1;
                        err   <= acc | r_bad;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
